lsu_align: RTL
==============

# lsu_align

Load/store unit between the single-cycle core's execute stage and the word-only data memory (256 × 32-bit, combinational read, posedge write, word index = address bits [9:2]). It converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into whole-word memory operations:
- sub-word stores become read-modify-write;
- loads are lane-extracted and sign- or zero-extended;
- misaligned accesses that cross a word boundary are split into two word operations, stalling the core for one extra cycle.

## Interface
Parameters:
- none (memory geometry fixed: 32-bit words, index = addr[9:2])

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  core presents a memory instruction this cycle
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data (rs2)
- stall  output  1  core must hold PC and all req_* stable next cycle
- rsp_valid  output  1  access completes this cycle
- rsp_rdata  output  32  extended load result (0 for stores and faults)
- rsp_fault  output  1  illegal funct3 for the direction, qualified by rsp_valid
- mem_read  output  1  to DMEM MemRead
- mem_write  output  1  to DMEM MemWrite
- mem_addr  output  32  word-aligned address to DMEM (bits [1:0] = 0)
- mem_wdata  output  32  merged word to DMEM
- mem_rdata  input  32  DMEM ReadData

## Operation
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- Illegal funct3 (any other value for the direction): mem_read = mem_write = 0, rsp_valid = 1, rsp_fault = 1, rsp_rdata = 0, no stall.
- Access parameters:
  - size = 1/2/4 bytes; off = req_addr[1:0]
  - split = (off + size > 4)
  - A = {req_addr[31:2], 2'b00}
  - B = A + 4, wrapping modulo 2^32; DMEM aliasing maps word 255 to 0
- Stores always assert mem_read, because a sub-word write needs the old word.
- Store merge:
  - first word: bytes off..min(3, off+size−1) of mem_rdata are replaced by req_wdata << 8·off
  - second word (split only): bytes 0..off+size−5 are replaced by req_wdata >> 8·(4−off)
  - SW with off = 0 writes req_wdata directly.
- Load extraction:
  - raw = ({second, first} >> 8·off), truncated to size bytes
  - signed codes sign-extend from bit 8·size−1; unsigned codes zero-extend
- FSM states: IDLE, SECOND.
  - IDLE with req_valid, legal, not split: mem_addr = A, single-cycle complete (rsp_valid = 1, stall = 0). Stay in IDLE.
  - IDLE with req_valid, legal, split:
    - mem_addr = A; store writes merged first word; load captures mem_rdata into the lo_hold register
    - stall = 1, rsp_valid = 0
    - next state SECOND
  - SECOND:
    - mem_addr = B; store writes merged second word; load forms the result from {mem_rdata, lo_hold}
    - rsp_valid = 1, stall = 0
    - next state IDLE
  - IDLE with req_valid = 0: all mem_* = 0, rsp_valid = 0.
- In SECOND, req_valid is ignored. The request is taken from the held inputs, which the core keeps stable.

## Timing
- Reset: state = IDLE, lo_hold = 0.
- Combinational outputs take their IDLE values, which depend on the request inputs:
  - with req_valid = 0: stall = 0, rsp_valid = 0, rsp_fault = 0, rsp_rdata = 0, mem_* = 0
- Latency:
  - aligned or non-split access, and faults: 0 extra cycles (response in the request cycle)
  - split access: 1 extra cycle
- The stall/rsp path is combinational from req_* in IDLE. Only state and lo_hold are registered.
- Store writes land at the posedge that ends each cycle in which mem_write = 1.
- A split store performs its two writes in consecutive cycles, word A first.
- Reset asserted in SECOND: return to IDLE immediately. The second half is abandoned and lo_hold is cleared.
- Wrap: req_addr = 0x3FF with LH:
  - A = 0x3FC, B = 0x400 (DMEM index 0)
  - the result is {word0[7:0], word255[31:24]}, sign-extended

## Structure
- Package lsu_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum lsu_state_t {IDLE, SECOND}
- Sub-module lsu_lane: purely combinational. Given funct3, offset, phase (first/second), old word and wdata, it produces the merged store word and the lane-extracted, extended load value.
- lsu_align holds the FSM, lo_hold and the output muxing.

## Test plan
- Aligned SW 0xDEADBEEF @0x10, then LW @0x10 → one cycle each, no stall, rsp_rdata 0xDEADBEEF.
- SB 0x80 @0x13 over word 0x11223344 → word becomes 0x80223344; LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080.
- Split SW 0xAABBCCDD @0x22 over words 0 → stall for 1 cycle; word 0x20 = 0xCCDD0000, word 0x24 = 0x0000AABB; LW @0x22 → stall then 0xAABBCCDD.
- Wrap LH @0x3FF with word255 = 0x7F000000 and word0 = 0x00000080 → rsp_rdata 0xFFFF807F after 1 stall cycle.
- Illegal funct3 011 on a load and 100 on a store → rsp_fault = 1, no mem_write, no stall, memory unchanged.
- rst_n pulsed low during SECOND of a split SH @0x0F → FSM returns to IDLE, stall = 0 next cycle, no second write issued.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes,
// FSM state type and access-size helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } lsu_state_t;

    // Access width in bytes (1, 2 or 4); only meaningful for legal codes.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: merges store data into an old word and extracts/extends
// load data, for either half of a possibly word-crossing access.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        phase,
    input  logic [31:0] old_word,
    input  logic [31:0] lo_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [3:0]  size_mask;
    logic [7:0]  mask64;
    logic [63:0] wdata64;
    logic [63:0] raw64;
    logic [3:0]  mask;
    logic [31:0] new_bytes;
    logic [31:0] raw;

    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase

        // Treat the two words as one 64-bit window; phase picks which half.
        mask64  = {4'b0000, size_mask} << off;
        wdata64 = {32'h0, wdata} << {off, 3'b000};

        if (phase) begin
            mask      = mask64[7:4];
            new_bytes = wdata64[63:32];
            raw64     = {old_word, lo_word} >> {off, 3'b000};
        end else begin
            mask      = mask64[3:0];
            new_bytes = wdata64[31:0];
            raw64     = {32'h0, old_word} >> {off, 3'b000};
        end

        store_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i])
                store_word[8*i +: 8] = new_bytes[8*i +: 8];
        end

        raw = raw64[31:0];
        case (funct3)
            F3_B:    load_data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    load_data = {{16{raw[15]}}, raw[15:0]};
            F3_W:    load_data = raw;
            F3_BU:   load_data = {24'h0, raw[7:0]};
            F3_HU:   load_data = {16'h0, raw[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store unit between execute and a word-only DMEM: read-modify-write for
// sub-word stores, lane extraction for loads, two-cycle split for word-crossers.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic [31:0] lo_hold;
    logic        lo_load;

    logic [1:0]  off;
    logic [2:0]  size;
    logic [2:0]  end_pos;
    logic        split;
    logic        legal;
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic        phase;
    logic [31:0] store_word;
    logic [31:0] load_data;

    assign off     = req_addr[1:0];
    assign size    = access_size(req_funct3);
    assign end_pos = {1'b0, off} + size;
    assign split   = (end_pos > 3'd4);
    assign legal   = f3_legal(req_we, req_funct3);
    assign addr_a  = {req_addr[31:2], 2'b00};
    assign addr_b  = addr_a + 32'd4;
    assign phase   = (state == SECOND);

    lsu_lane u_lane (
        .funct3     (req_funct3),
        .off        (off),
        .phase      (phase),
        .old_word   (mem_rdata),
        .lo_word    (lo_hold),
        .wdata      (req_wdata),
        .store_word (store_word),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lo_hold <= 32'h0;
        end else begin
            state <= state_next;
            if (lo_load)
                lo_hold <= mem_rdata;
        end
    end

    always_comb begin
        state_next = state;
        lo_load    = 1'b0;
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        rsp_fault  = 1'b0;
        rsp_rdata  = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!legal) begin
                        rsp_valid = 1'b1;
                        rsp_fault = 1'b1;
                    end else begin
                        // Stores read too: the old word feeds the merge.
                        mem_read  = 1'b1;
                        mem_write = req_we;
                        mem_addr  = addr_a;
                        mem_wdata = req_we ? store_word : 32'h0;
                        if (split) begin
                            stall      = 1'b1;
                            lo_load    = !req_we;
                            state_next = SECOND;
                        end else begin
                            rsp_valid = 1'b1;
                            rsp_rdata = req_we ? 32'h0 : load_data;
                        end
                    end
                end
            end
            SECOND: begin
                // Request fields are held stable by the core; req_valid is ignored.
                mem_read   = 1'b1;
                mem_write  = req_we;
                mem_addr   = addr_b;
                mem_wdata  = req_we ? store_word : 32'h0;
                rsp_valid  = 1'b1;
                rsp_rdata  = req_we ? 32'h0 : load_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
